// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART receiver and transmitter; launches one stored byte per transmitter frame.
// Latency: a write into an empty FIFO with an idle transmitter produces tx_en one cycle after the write edge.
// Backpressure: launches wait for tx_rdy; writes arriving while full are dropped and flagged by sticky overflow.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  tx_rdy,
   output logic                  tx_en,
   output logic [DATA_W-1:0]     tx_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOW  = 2'd1,
      WAIT_HIGH = 2'd2
   } state_t;

   state_t                  state;
   logic [DATA_W-1:0]       mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic                    wr_acc;
   logic                    pop;
   logic [DEPTH_LOG2:0]     next_count;

   // Full is taken from the registered count, so a write while full is dropped even if a pop happens that cycle.
   assign wr_acc = wr_en && !full;
   assign pop    = (state == IDLE) && (count != '0) && tx_rdy;

   // Occupancy for the next cycle: simultaneous accepted write and pop leaves it unchanged.
   always_comb begin
      next_count = count;
      case ({wr_acc, pop})
         2'b10:   next_count = count + 1'b1;
         2'b01:   next_count = count - 1'b1;
         default: next_count = count;
      endcase
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Write pointer, occupancy, full flag and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         count <= next_count;
         full  <= (next_count == FULL_CNT);
      end
   end

   // Launch FSM: pop one byte when the transmitter is idle, then wait for it to go busy and idle again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rd_ptr  <= '0;
         tx_en   <= 1'b0;
         tx_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= mem[rd_ptr];
                  rd_ptr  <= rd_ptr + 1'b1;
                  tx_en   <= 1'b1;
                  state   <= WAIT_LOW;
               end else begin
                  tx_en <= 1'b0;
               end
            end
            WAIT_LOW: begin
               tx_en <= 1'b0;
               if (!tx_rdy) begin
                  state <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               tx_en <= 1'b0;
               if (tx_rdy) begin
                  state <= IDLE;
               end
            end
            default: begin
               tx_en <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed an expected-byte queue; a monitor checks each tx_en launch.
// A simple transmitter model drops rdy the cycle after en and holds it low for frame_len cycles.
// hold forces rdy low to let the FIFO fill.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        full;
   logic [4:0]  count;
   logic        overflow;
   logic        tx_rdy;
   logic        tx_en;
   logic [7:0]  tx_data;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q [$];
   int          peak = 0;
   logic        prev_en = 1'b0;
   logic        hold = 1'b0;
   int          frame_len = 10;
   int          busy = 0;

   uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .tx_rdy   (tx_rdy),
      .tx_en    (tx_en),
      .tx_data  (tx_data)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy for frame_len cycles after each accepted launch.
   always @(posedge clk) begin
      if (rst) busy <= 0;
      else if (tx_en) busy <= frame_len;
      else if (busy != 0) busy <= busy - 1;
   end
   assign tx_rdy = !hold && (busy == 0);

   // Monitor: every launch must be a single-cycle pulse carrying the oldest expected byte.
   always @(negedge clk) begin
      if (int'(count) > peak) peak = int'(count);
      if (tx_en) begin
         checks++;
         if (prev_en) begin
            errors++;
            $display("FAIL tx_en_pulse: tx_en high on consecutive cycles, required single-cycle pulse");
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %02h, required no launch", tx_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               errors++;
               $display("FAIL launch_order: got %02h, required %02h", tx_data, e);
            end
         end
      end
      prev_en = tx_en;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // One write strobe sampled at the next rising edge; returns on the following falling edge.
   task automatic push(input logic [7:0] b, input bit expect_acc);
      wr_data = b;
      wr_en   = 1'b1;
      if (expect_acc) exp_q.push_back(b);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic drain(input string name, input int limit);
      bit done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && count == 5'd0 && tx_rdy && !tx_en) done = 1'b1;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s: drain timeout, %0d bytes still expected, count=%0d", name, exp_q.size(), count);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_tx_en", 32'(tx_en), 32'd0);
      chk("reset_tx_data", 32'(tx_data), 32'h00);

      // Single byte: tx_en one edge after the write edge, for exactly one cycle.
      frame_len = 10;
      push(8'h41, 1'b1);
      @(posedge clk); #1;
      chk("single_tx_en", 32'(tx_en), 32'd1);
      chk("single_tx_data", 32'(tx_data), 32'h41);
      chk("single_count", 32'(count), 32'd0);
      @(posedge clk); #1;
      chk("single_tx_en_drop", 32'(tx_en), 32'd0);
      drain("single_drain", 200);

      // Burst of five against a slow transmitter.
      frame_len = 100;
      peak = 0;
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b1);
      drain("burst_drain", 2000);
      checks++;
      if (peak < 4 || peak > 5) begin
         errors++;
         $display("FAIL burst_peak: got %0d, required 4 or 5", peak);
      end
      chk("burst_overflow", 32'(overflow), 32'd0);

      // Fill to 16 with rdy held low; the 17th write is dropped.
      frame_len = 3;
      @(negedge clk); hold = 1'b1;
      for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i), 1'b1);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_overflow_pre", 32'(overflow), 32'd0);
      push(8'hEE, 1'b0);
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_count_hold", 32'(count), 32'd16);
      hold = 1'b0;
      drain("fill_drain", 1000);

      // Simultaneous write and pop at count 3.
      hold = 1'b1;
      push(8'h31, 1'b1); push(8'h32, 1'b1); push(8'h33, 1'b1);
      chk("simul_count_pre", 32'(count), 32'd3);
      hold = 1'b0;
      push(8'h34, 1'b1);
      chk("simul_count", 32'(count), 32'd3);
      chk("simul_tx_en", 32'(tx_en), 32'd1);
      chk("simul_oldest", 32'(tx_data), 32'h31);
      drain("simul_drain", 500);

      // Forty bytes through the 16-entry ring, wrapping both pointers.
      frame_len = 2;
      for (int i = 0; i < 40; i++) begin
         push(8'(i * 7 + 3), 1'b1);
         repeat (10) @(negedge clk);
      end
      drain("wrap_drain", 500);
      chk("wrap_count", 32'(count), 32'd0);

      // Reset while waiting on a long frame with seven bytes queued.
      frame_len = 200;
      for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1'b1);
      repeat (3) @(negedge clk);
      chk("rst_count_pre", 32'(count), 32'd7);
      chk("rst_rdy_busy", 32'(tx_rdy), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_tx_en", 32'(tx_en), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      frame_len = 5;
      push(8'h5A, 1'b1);
      @(posedge clk); #1;
      chk("post_rst_tx_en", 32'(tx_en), 32'd1);
      chk("post_rst_tx_data", 32'(tx_data), 32'h5A);
      drain("post_rst_drain", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the UART Receiver output (data_rx/valid) and the Transmitter input (data_tx/en/rdy). It absorbs bursts of received bytes and launches them one at a time into the Transmitter, which cannot accept a new byte while it is shifting one out. In the echo path it replaces the direct valid-to-en connection, so back-to-back received bytes are never lost while TX is busy.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..8
DATA_W, 8, byte width; fixed at 8 for UART use

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
wr_data  input  DATA_W  byte from Receiver data_rx
wr_en  input  1  one-cycle write strobe from Receiver valid
full  output  1  FIFO holds 2^DEPTH_LOG2 entries
count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
overflow  output  1  sticky: a write was dropped because FIFO was full
tx_rdy  input  1  Transmitter rdy (high = idle, can accept byte)
tx_en  output  1  one-cycle launch strobe to Transmitter en
tx_data  output  DATA_W  byte to Transmitter data_tx

Behaviour:
- One clock, clk; reset synchronous and active-high on rst. All outputs registered.
- Reset values: count=0, full=0, overflow=0, tx_en=0, tx_data=0; wr/rd pointers=0; state=IDLE. Reset mid-transfer discards all stored bytes and returns to IDLE in the next cycle; tx_en is low the cycle after rst is sampled high.
- Storage: circular buffer of 2^DEPTH_LOG2 x DATA_W; wr_ptr/rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth. count is tracked in a separate register.
- Write: at a rising edge with wr_en=1 and full=0, store wr_data at wr_ptr and advance wr_ptr. With wr_en=1 and full=1, drop the byte and set overflow=1 (cleared only by rst). full is evaluated on the registered count: a write while full is dropped even if a pop occurs in the same cycle.
- Pop/launch FSM:
  - IDLE: if count!=0 and tx_rdy=1, then at the edge tx_data<=mem[rd_ptr], rd_ptr++, tx_en<=1, go to WAIT_LOW. Otherwise tx_en<=0.
  - WAIT_LOW: tx_en<=0. Wait for tx_rdy=0 (Transmitter accepted), then go to WAIT_HIGH. Transmitter contract: rdy drops within 2 cycles of en.
  - WAIT_HIGH: wait for tx_rdy=1 (byte fully shifted out), then go to IDLE.
- tx_en is high for exactly one cycle per launched byte. tx_data is stable from the launch edge until the next launch.
- count update: +1 on accepted write only, -1 on pop only, unchanged on simultaneous accepted write and pop. full = (count == 2^DEPTH_LOG2).
- Latency: write sampled at edge N into an empty FIFO with tx_rdy=1 and FSM in IDLE gives tx_en high after edge N+1 (1-cycle latency), with tx_data = written byte.
- Byte order is strictly preserved (FIFO). Each accepted byte is launched exactly once.
- Minimum spacing between launches: the Transmitter frame time, plus 1 cycle for IDLE re-evaluation.

Test Plan:
- Reset then a single write 0x41 with tx_rdy=1 -> tx_en high for exactly 1 cycle, one edge after the write; tx_data=0x41; count returns to 0.
- Burst of 5 writes 0x10..0x14 on consecutive cycles while a Transmitter model holds rdy low for 100 cycles per byte -> count peaks at 4 or 5; five tx_en pulses in order 0x10..0x14; no overflow.
- With tx_rdy held 0, write 17 bytes at DEPTH_LOG2=4 -> full=1 after the 16th write, count=16, 17th byte dropped, overflow=1; after rdy is released, 16 bytes are output in order and the 17th never appears.
- Simultaneous write and pop at count=3 -> count stays 3; the popped byte is the oldest; the written byte is appended last.
- Pointer wrap: push and pop 40 bytes through a 16-deep FIFO -> output sequence equals input sequence; count ends at 0.
- Assert rst while in WAIT_HIGH with count=7 -> the next cycle shows count=0, tx_en=0, overflow=0, state IDLE; a subsequent write launches normally.
